// File: rtl/llc_mem_arbiter.sv
// llc_mem_arbiter
// Shares one memory request/response port among NUM_BANKS LLC banks.
// Bank requests (read fills and dirty writebacks) are arbitrated round-robin
// into a single registered request slot. Every issued read pushes its bank
// index into an in-order tag FIFO; memory responses are steered back to the
// bank at the FIFO head. Writes produce no response and no FIFO entry.
//
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   bank_req_*           per-bank request channel (flattened vectors)
//   mem_req_*            registered request channel to memory
//   mem_rsp_*            response channel from memory
//   bank_rsp_*           per-bank response channel (shared line data)
//   outstanding          number of reads in flight
//   orphan_rsp_err       sticky flag: response arrived with no read in flight
module llc_mem_arbiter #(
  parameter int NUM_BANKS       = 4,
  parameter int MAX_OUTSTANDING = 8,
  parameter int ADDR_W          = 26,
  parameter int LINE_W          = 128,
  parameter int HPROT_W         = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_BANKS-1:0]                bank_req_valid,
  output logic [NUM_BANKS-1:0]                bank_req_ready,
  input  logic [NUM_BANKS-1:0]                bank_req_hwrite,
  input  logic [NUM_BANKS*ADDR_W-1:0]         bank_req_addr,
  input  logic [NUM_BANKS*HPROT_W-1:0]        bank_req_hprot,
  input  logic [NUM_BANKS*LINE_W-1:0]         bank_req_line,
  output logic                                mem_req_valid,
  input  logic                                mem_req_ready,
  output logic                                mem_req_hwrite,
  output logic [ADDR_W-1:0]                   mem_req_addr,
  output logic [HPROT_W-1:0]                  mem_req_hprot,
  output logic [LINE_W-1:0]                   mem_req_line,
  input  logic                                mem_rsp_valid,
  output logic                                mem_rsp_ready,
  input  logic [LINE_W-1:0]                   mem_rsp_line,
  output logic [NUM_BANKS-1:0]                bank_rsp_valid,
  input  logic [NUM_BANKS-1:0]                bank_rsp_ready,
  output logic [LINE_W-1:0]                   bank_rsp_line,
  output logic [$clog2(MAX_OUTSTANDING):0]    outstanding,
  output logic                                orphan_rsp_err
);

  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int PTR_W  = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic [BANK_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic               req_valid_q, req_valid_d;
  logic               req_hwrite_q, req_hwrite_d;
  logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
  logic [HPROT_W-1:0] req_hprot_q, req_hprot_d;
  logic [LINE_W-1:0]  req_line_q, req_line_d;
  logic [BANK_W-1:0]  tag_mem_q [MAX_OUTSTANDING];
  logic [BANK_W-1:0]  tag_mem_d [MAX_OUTSTANDING];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               orphan_q, orphan_d;

  logic                 slot_free;
  logic [NUM_BANKS-1:0] eligible;
  logic                 gnt_found;
  logic                 gnt_valid;
  logic [BANK_W-1:0]    gnt_idx;
  logic [BANK_W-1:0]    cand;
  logic                 push;
  logic                 pop;
  logic                 fifo_empty;
  logic [BANK_W-1:0]    head;

  // Round-robin grant. Reads are held back once the tag FIFO is full, judged
  // on the registered count so a same-cycle pop never frees a slot early.
  always_comb begin
    slot_free = !req_valid_q || mem_req_ready;
    for (int i = 0; i < NUM_BANKS; i++) begin
      eligible[i] = bank_req_valid[i] & (bank_req_hwrite[i] | (count_q < MAX_CNT));
    end
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      cand = rr_ptr_q + BANK_W'(k);
      if (!gnt_found && eligible[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
    gnt_valid      = slot_free & gnt_found;
    bank_req_ready = '0;
    if (gnt_valid) bank_req_ready[gnt_idx] = 1'b1;
    push = gnt_valid & ~bank_req_hwrite[gnt_idx];
  end

  // Response steering: the FIFO head names the bank owed the next line.
  // With nothing in flight a response is an orphan and is never accepted.
  always_comb begin
    fifo_empty     = (count_q == '0);
    head           = tag_mem_q[rd_ptr_q];
    bank_rsp_valid = '0;
    mem_rsp_ready  = 1'b0;
    if (!fifo_empty) begin
      bank_rsp_valid[head] = mem_rsp_valid;
      mem_rsp_ready        = bank_rsp_ready[head];
    end
    pop           = mem_rsp_valid & mem_rsp_ready;
    bank_rsp_line = mem_rsp_line;
  end

  // Next-state: request slot loads on a grant, otherwise empties once taken.
  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    req_valid_d  = req_valid_q;
    req_hwrite_d = req_hwrite_q;
    req_addr_d   = req_addr_q;
    req_hprot_d  = req_hprot_q;
    req_line_d   = req_line_q;
    tag_mem_d    = tag_mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    orphan_d     = orphan_q | (mem_rsp_valid & fifo_empty);

    if (gnt_valid) begin
      rr_ptr_d     = gnt_idx + BANK_W'(1);
      req_valid_d  = 1'b1;
      req_hwrite_d = bank_req_hwrite[gnt_idx];
      req_addr_d   = bank_req_addr[gnt_idx*ADDR_W +: ADDR_W];
      req_hprot_d  = bank_req_hprot[gnt_idx*HPROT_W +: HPROT_W];
      req_line_d   = bank_req_line[gnt_idx*LINE_W +: LINE_W];
    end else if (mem_req_ready) begin
      req_valid_d = 1'b0;
    end

    if (push) begin
      tag_mem_d[wr_ptr_q] = gnt_idx;
      wr_ptr_d            = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q     <= '0;
      req_valid_q  <= 1'b0;
      req_hwrite_q <= 1'b0;
      req_addr_q   <= '0;
      req_hprot_q  <= '0;
      req_line_q   <= '0;
      tag_mem_q    <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      orphan_q     <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      req_valid_q  <= req_valid_d;
      req_hwrite_q <= req_hwrite_d;
      req_addr_q   <= req_addr_d;
      req_hprot_q  <= req_hprot_d;
      req_line_q   <= req_line_d;
      tag_mem_q    <= tag_mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      orphan_q     <= orphan_d;
    end
  end

  assign mem_req_valid  = req_valid_q;
  assign mem_req_hwrite = req_hwrite_q;
  assign mem_req_addr   = req_addr_q;
  assign mem_req_hprot  = req_hprot_q;
  assign mem_req_line   = req_line_q;
  assign outstanding    = count_q;
  assign orphan_rsp_err = orphan_q;

endmodule

// File: tb/tb_llc_mem_arbiter.sv
// tb_llc_mem_arbiter
// Directed stimulus for llc_mem_arbiter. Expected memory requests and bank
// responses are queued as each vector is issued; a monitor pops and compares
// them whenever a request or response handshake occurs on the DUT.
module tb_llc_mem_arbiter;

  localparam int NB      = 4;
  localparam int MAXO    = 8;
  localparam int ADDR_W  = 26;
  localparam int LINE_W  = 128;
  localparam int HPROT_W = 2;
  localparam int CNT_W   = $clog2(MAXO) + 1;

  typedef struct {
    logic               hwrite;
    logic [ADDR_W-1:0]  addr;
    logic [HPROT_W-1:0] hprot;
    logic [LINE_W-1:0]  line;
  } req_t;

  typedef struct {
    int                bank;
    logic [LINE_W-1:0] line;
  } rsp_t;

  logic                    clk;
  logic                    rst;
  logic [NB-1:0]           bank_req_valid;
  logic [NB-1:0]           bank_req_ready;
  logic [NB-1:0]           bank_req_hwrite;
  logic [NB*ADDR_W-1:0]    bank_req_addr;
  logic [NB*HPROT_W-1:0]   bank_req_hprot;
  logic [NB*LINE_W-1:0]    bank_req_line;
  logic                    mem_req_valid;
  logic                    mem_req_ready;
  logic                    mem_req_hwrite;
  logic [ADDR_W-1:0]       mem_req_addr;
  logic [HPROT_W-1:0]      mem_req_hprot;
  logic [LINE_W-1:0]       mem_req_line;
  logic                    mem_rsp_valid;
  logic                    mem_rsp_ready;
  logic [LINE_W-1:0]       mem_rsp_line;
  logic [NB-1:0]           bank_rsp_valid;
  logic [NB-1:0]           bank_rsp_ready;
  logic [LINE_W-1:0]       bank_rsp_line;
  logic [CNT_W-1:0]        outstanding;
  logic                    orphan_rsp_err;

  int   checks = 0;
  int   errors = 0;
  req_t exp_req[$];
  rsp_t exp_rsp[$];
  req_t mon_req;
  rsp_t mon_rsp;

  llc_mem_arbiter #(
    .NUM_BANKS(NB), .MAX_OUTSTANDING(MAXO), .ADDR_W(ADDR_W),
    .LINE_W(LINE_W), .HPROT_W(HPROT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .bank_req_valid(bank_req_valid), .bank_req_ready(bank_req_ready),
    .bank_req_hwrite(bank_req_hwrite), .bank_req_addr(bank_req_addr),
    .bank_req_hprot(bank_req_hprot), .bank_req_line(bank_req_line),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_hwrite(mem_req_hwrite), .mem_req_addr(mem_req_addr),
    .mem_req_hprot(mem_req_hprot), .mem_req_line(mem_req_line),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
    .mem_rsp_line(mem_rsp_line),
    .bank_rsp_valid(bank_rsp_valid), .bank_rsp_ready(bank_rsp_ready),
    .bank_rsp_line(bank_rsp_line),
    .outstanding(outstanding), .orphan_rsp_err(orphan_rsp_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [LINE_W-1:0] bank_line(input int b);
    logic [7:0] byte_val;
    byte_val = 8'h10 + 8'(b);
    return {16{byte_val}};
  endfunction

  task automatic check_output(input string name, input logic [LINE_W-1:0] act,
                              input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_bank(input int b, input logic v, input logic w,
                          input logic [ADDR_W-1:0] a);
    bank_req_valid[b]                      = v;
    bank_req_hwrite[b]                     = w;
    bank_req_addr[b*ADDR_W +: ADDR_W]      = a;
    bank_req_hprot[b*HPROT_W +: HPROT_W]   = HPROT_W'(b);
    bank_req_line[b*LINE_W +: LINE_W]      = bank_line(b);
  endtask

  task automatic push_req(input logic w, input logic [ADDR_W-1:0] a, input int b);
    req_t r;
    r.hwrite = w;
    r.addr   = a;
    r.hprot  = HPROT_W'(b);
    r.line   = bank_line(b);
    exp_req.push_back(r);
  endtask

  task automatic push_rsp(input int b, input logic [LINE_W-1:0] l);
    rsp_t r;
    r.bank = b;
    r.line = l;
    exp_rsp.push_back(r);
  endtask

  // Drive one memory response and hold it until the DUT accepts it.
  task automatic send_rsp(input int b, input logic [LINE_W-1:0] l);
    int n;
    push_rsp(b, l);
    mem_rsp_valid = 1'b1;
    mem_rsp_line  = l;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_rsp_ready && n < 20);
    if (!mem_rsp_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL rsp_timeout: mem_rsp_ready got 0, expected 1 within 20 cycles");
    end
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
  endtask

  task automatic apply_reset();
    rst             = 1'b0;
    bank_req_valid  = '0;
    bank_req_hwrite = '0;
    bank_req_addr   = '0;
    bank_req_hprot  = '0;
    bank_req_line   = '0;
    mem_req_ready   = 1'b1;
    mem_rsp_valid   = 1'b0;
    mem_rsp_line    = '0;
    bank_rsp_ready  = '1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // All four banks request reads continuously; from rr_ptr=0 the grants go
  // 0,1,2,3,0,1,2,3, one per cycle, filling the tag FIFO exactly.
  task automatic issue_burst8();
    for (int k = 0; k < 8; k++) push_req(1'b0, ADDR_W'(26'h100 + k % 4), k % 4);
    @(posedge clk); #1;
    for (int i = 0; i < NB; i++) set_bank(i, 1'b1, 1'b0, ADDR_W'(26'h100 + i));
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check_output($sformatf("burst_grant%0d", k), bank_req_ready, NB'(1) << (k % 4));
      @(posedge clk); #1;
    end
    bank_req_valid = '0;
  endtask

  // Scoreboard monitor: compare on every request and response handshake.
  always @(negedge clk) begin
    if (rst) begin
      if (mem_req_valid && mem_req_ready) begin
        if (exp_req.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_req: got addr %0h, expected no request", mem_req_addr);
        end else begin
          mon_req = exp_req.pop_front();
          check_output("req_hwrite", mem_req_hwrite, mon_req.hwrite);
          check_output("req_addr", mem_req_addr, mon_req.addr);
          check_output("req_hprot", mem_req_hprot, mon_req.hprot);
          check_output("req_line", mem_req_line, mon_req.line);
        end
      end
      if (mem_rsp_valid && mem_rsp_ready) begin
        if (exp_rsp.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_rsp: got bank_rsp_valid %0b, expected no response", bank_rsp_valid);
        end else begin
          mon_rsp = exp_rsp.pop_front();
          check_output("rsp_bank", bank_rsp_valid, NB'(1) << mon_rsp.bank);
          check_output("rsp_line", bank_rsp_line, mon_rsp.line);
        end
      end
    end
  end

  initial begin
    // Reset state
    apply_reset();
    @(negedge clk);
    check_output("rst_mem_req_valid", mem_req_valid, 0);
    check_output("rst_mem_req_addr", mem_req_addr, 0);
    check_output("rst_mem_req_line", mem_req_line, 0);
    check_output("rst_outstanding", outstanding, 0);
    check_output("rst_orphan", orphan_rsp_err, 0);
    check_output("rst_bank_req_ready", bank_req_ready, 0);
    check_output("rst_mem_rsp_ready", mem_rsp_ready, 0);

    // Single read from bank 2
    push_req(1'b0, 26'h12345, 2);
    @(posedge clk); #1;
    set_bank(2, 1'b1, 1'b0, 26'h12345);
    @(negedge clk);
    check_output("t1_grant", bank_req_ready, 4'b0100);
    @(posedge clk); #1;
    set_bank(2, 1'b0, 1'b0, 26'h12345);
    @(negedge clk);
    check_output("t1_req_valid", mem_req_valid, 1);
    check_output("t1_outstanding", outstanding, 1);
    @(posedge clk); #1;
    send_rsp(2, {16{8'hA5}});
    @(negedge clk);
    check_output("t1_outstanding_after", outstanding, 0);
    check_output("t1_req_valid_after", mem_req_valid, 0);

    // Round-robin burst and in-order response routing
    apply_reset();
    issue_burst8();
    @(negedge clk);
    check_output("t2_outstanding_full", outstanding, 8);
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) send_rsp(k % 4, {16{8'(8'hC0 + k)}});
    @(negedge clk);
    check_output("t2_outstanding_drained", outstanding, 0);

    // Full FIFO: reads stall, writes proceed
    apply_reset();
    issue_burst8();
    set_bank(0, 1'b1, 1'b0, 26'h200);
    set_bank(1, 1'b1, 1'b1, 26'h301);
    push_req(1'b1, 26'h301, 1);
    @(negedge clk);
    check_output("t3_write_grant", bank_req_ready, 4'b0010);
    @(posedge clk); #1;
    set_bank(1, 1'b0, 1'b1, 26'h301);
    push_rsp(0, {16{8'h3C}});
    mem_rsp_valid = 1'b1;
    mem_rsp_line  = {16{8'h3C}};
    @(negedge clk);
    check_output("t3_read_stalled", bank_req_ready, 0);
    check_output("t3_outstanding_held", outstanding, 8);
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    push_req(1'b0, 26'h200, 0);
    @(negedge clk);
    check_output("t3_read_resumes", bank_req_ready, 4'b0001);
    check_output("t3_outstanding_7", outstanding, 7);
    @(posedge clk); #1;
    set_bank(0, 1'b0, 1'b0, 26'h200);
    @(negedge clk);
    check_output("t3_outstanding_refill", outstanding, 8);
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) send_rsp((k + 1) % 4, {16{8'(8'hD0 + k)}});

    // Backpressure on the memory request channel
    apply_reset();
    mem_req_ready = 1'b0;
    push_req(1'b0, 26'h400, 0);
    push_req(1'b0, 26'h401, 1);
    @(posedge clk); #1;
    set_bank(0, 1'b1, 1'b0, 26'h400);
    set_bank(1, 1'b1, 1'b0, 26'h401);
    @(negedge clk);
    check_output("t4_first_grant", bank_req_ready, 4'b0001);
    @(posedge clk); #1;
    set_bank(0, 1'b0, 1'b0, 26'h400);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_output("t4_hold_no_grant", bank_req_ready, 0);
      check_output("t4_hold_valid", mem_req_valid, 1);
      check_output("t4_hold_addr", mem_req_addr, 26'h400);
      @(posedge clk); #1;
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    check_output("t4_grant_on_handshake", bank_req_ready, 4'b0010);
    @(posedge clk); #1;
    set_bank(1, 1'b0, 1'b0, 26'h401);
    @(negedge clk);
    @(posedge clk); #1;
    send_rsp(0, {16{8'hE0}});
    send_rsp(1, {16{8'hE1}});

    // Head bank not ready holds the response
    apply_reset();
    push_req(1'b0, 26'h3AB, 3);
    @(posedge clk); #1;
    set_bank(3, 1'b1, 1'b0, 26'h3AB);
    @(negedge clk);
    @(posedge clk); #1;
    set_bank(3, 1'b0, 1'b0, 26'h3AB);
    bank_rsp_ready = 4'b0111;
    push_rsp(3, {16{8'h5A}});
    mem_rsp_valid = 1'b1;
    mem_rsp_line  = {16{8'h5A}};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_output("t5_rsp_ready_low", mem_rsp_ready, 0);
      check_output("t5_rsp_valid_bank3", bank_rsp_valid, 4'b1000);
      check_output("t5_no_pop", outstanding, 1);
      @(posedge clk); #1;
    end
    bank_rsp_ready = 4'b1111;
    @(negedge clk);
    check_output("t5_rsp_ready_high", mem_rsp_ready, 1);
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    check_output("t5_single_pop", outstanding, 0);

    // Orphan response sets a sticky error
    @(posedge clk); #1;
    mem_rsp_valid = 1'b1;
    mem_rsp_line  = {16{8'h77}};
    @(negedge clk);
    check_output("t6_orphan_not_accepted", mem_rsp_ready, 0);
    check_output("t6_orphan_no_bank_valid", bank_rsp_valid, 0);
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    check_output("t6_orphan_set", orphan_rsp_err, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("t6_orphan_sticky", orphan_rsp_err, 1);

    // Asynchronous reset with a request pending and a read in flight
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    set_bank(1, 1'b1, 1'b0, 26'h111);
    @(posedge clk); #1;
    set_bank(1, 1'b0, 1'b0, 26'h111);
    @(negedge clk);
    check_output("t7_pre_outstanding", outstanding, 1);
    check_output("t7_pre_valid", mem_req_valid, 1);
    #2 rst = 1'b0;
    #1;
    check_output("t7_async_valid", mem_req_valid, 0);
    check_output("t7_async_addr", mem_req_addr, 0);
    check_output("t7_async_outstanding", outstanding, 0);
    check_output("t7_async_orphan", orphan_rsp_err, 0);
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);

    check_output("end_req_queue_empty", exp_req.size(), 0);
    check_output("end_rsp_queue_empty", exp_rsp.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
